// File: rtl/positaccum_round_16_pkg.sv
// rtl/positaccum_round_16_pkg.sv - shared constants, round record type and regime helper for the posit<16,2> packer
package positaccum_round_16_pkg;

    // Serialized accumulator word: [157]sgn [156:149]scale [148:2]fraction [1]inf [0]zero
    localparam int POSIT_SERIALIZED_WIDTH_ACCUM_ES2 = 158;
    localparam int FBITS_ACCUM                      = 147;
    // Aligned body: up to 16 regime bits + 2 exponent bits + fraction
    localparam int BODY_W                           = FBITS_ACCUM + 18;

    localparam int          POSIT16_ES2_MAXSCALE = 56;
    localparam logic [15:0] POSIT16_NAR          = 16'h8000;
    localparam logic [15:0] POSIT16_MAXPOS       = 16'h7FFF;
    localparam logic [15:0] POSIT16_MINPOS       = 16'h0001;

    typedef struct packed {
        logic [14:0] mag;
        logic        guard;
        logic        sticky;
        logic        sgn;
        logic        inf;
        logic        zero;
    } posit16_round_t;

    // Length of the regime run (identical bits before the terminator)
    function automatic logic [4:0] regime_run(input logic signed [5:0] k);
        return (k >= 0) ? 5'(k + 6'sd1) : 5'(-k);
    endfunction

endpackage

// File: rtl/posit_skid2.sv
// rtl/posit_skid2.sv - 2-entry FIFO-ordered valid/ready skid buffer
module posit_skid2 #(
    parameter int W = 18
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] s_tdata,
    input  logic         s_tvalid,
    output logic [W-1:0] m_tdata,
    output logic         m_tvalid,
    input  logic         m_tready,
    output logic         full
);

    logic [W-1:0] mem0, mem1;
    logic         rd_ptr;
    logic         wr_ptr;
    logic [1:0]   count;
    logic         push, pop;

    assign m_tvalid = (count != 2'd0);
    assign full     = (count == 2'd2);
    assign pop      = m_tready & m_tvalid;
    // A push into a full buffer is only accepted when the head leaves the same cycle
    assign push     = s_tvalid & (~full | pop);
    assign wr_ptr   = rd_ptr ^ count[0];
    assign m_tdata  = rd_ptr ? mem1 : mem0;

    // Storage, read pointer and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem0   <= '0;
            mem1   <= '0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                if (wr_ptr) mem1 <= s_tdata;
                else        mem0 <= s_tdata;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/shift_right.sv
// rtl/shift_right.sv - zero-filling logical right shifter
module shift_right #(
    parameter int N = 8,
    parameter int S = 3
) (
    input  logic [N-1:0] din,
    input  logic [S-1:0] shamt,
    output logic [N-1:0] dout
);

    assign dout = din >> shamt;

endmodule

// File: rtl/positaccum_round_16.sv
// rtl/positaccum_round_16.sv - packs accumulator result into posit<16,2> with RNE; option POSIT_ACCUM_STICKY_EN
module positaccum_round_16
    import positaccum_round_16_pkg::*;
#(
    parameter int NBITS      = 16,
    parameter int ES         = 2,
    parameter int SKID_DEPTH = 2
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [POSIT_SERIALIZED_WIDTH_ACCUM_ES2-1:0] in_data,
    input  logic                                        in_valid,
    input  logic                                        in_truncated,
    output logic                                        in_ready,
    output logic [15:0]                                 out_posit,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic                                        out_inexact,
    output logic                                        out_nar,
    output logic                                        overrun
);

    if (NBITS != 16) begin : g_nbits_chk
        $error("positaccum_round_16: only NBITS=16 is supported");
    end
    if (ES != 2) begin : g_es_chk
        $error("positaccum_round_16: only ES=2 is supported");
    end
    if (SKID_DEPTH != 2) begin : g_skid_chk
        $error("positaccum_round_16: only SKID_DEPTH=2 is supported");
    end

    logic pipe_en;
    logic skid_full;

    // ---------------- S1: field capture ----------------
    logic                    s1_valid, s1_sgn, s1_inf, s1_zero;
    logic signed [7:0]       s1_scale;
    logic signed [5:0]       s1_k;
    logic [1:0]              s1_e;
    logic [FBITS_ACCUM-1:0]  s1_frac;
    logic signed [7:0]       in_scale;
    logic                    sticky_extra;

    assign in_scale = in_data[156:149];

    // Register the serialized fields and split scale into regime k and exponent e
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sgn   <= 1'b0;
            s1_scale <= '0;
            s1_k     <= '0;
            s1_e     <= '0;
            s1_frac  <= '0;
            s1_inf   <= 1'b0;
            s1_zero  <= 1'b0;
        end else if (pipe_en) begin
            s1_valid <= in_valid;
            s1_sgn   <= in_data[157];
            s1_scale <= in_scale;
            s1_k     <= 6'(in_scale >>> 2);
            s1_e     <= in_scale[1:0];
            s1_frac  <= in_data[148:2];
            s1_inf   <= in_data[1];
            s1_zero  <= in_data[0];
        end
    end

`ifdef POSIT_ACCUM_STICKY_EN
    logic s1_trunc;

    // Truncation from the accumulator travels with its value and joins the sticky bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          s1_trunc <= 1'b0;
        else if (pipe_en) s1_trunc <= in_truncated;
    end
    assign sticky_extra = s1_trunc;
`else
    logic unused_trunc;
    assign unused_trunc = in_truncated;
    assign sticky_extra = 1'b0;
`endif

    // ---------------- S2: regime build, alignment, clamp ----------------
    // The run bits are shifted in from the top; a run of ones is produced by
    // shifting the complement with zero fill and complementing back.
    logic              run_ones;
    logic [4:0]        run_len;
    logic [BODY_W-1:0] body_raw, sh_in, sh_out, body;
    posit16_round_t    s2_d, s2_q;
    logic              s2_valid;

    assign run_ones = ~s1_k[5];
    assign run_len  = regime_run(s1_k);
    assign body_raw = {s1_k[5], s1_e, s1_frac, 15'd0};
    assign sh_in    = run_ones ? ~body_raw : body_raw;
    assign body     = run_ones ? ~sh_out : sh_out;

    shift_right #(.N(BODY_W), .S(5)) u_align (
        .din   (sh_in),
        .shamt (run_len),
        .dout  (sh_out)
    );

    // Slice the top 15 bits, derive guard/sticky, and override with clamp values
    always_comb begin
        s2_d.mag    = body[BODY_W-1 -: 15];
        s2_d.guard  = body[BODY_W-16];
        s2_d.sticky = (|body[BODY_W-17:0]) | sticky_extra;
        s2_d.sgn    = s1_sgn;
        s2_d.inf    = s1_inf;
        s2_d.zero   = s1_zero;
        // Clamped results are marked inexact via sticky with guard=0, so they never round
        if (int'(s1_scale) > POSIT16_ES2_MAXSCALE) begin
            s2_d.mag    = POSIT16_MAXPOS[14:0];
            s2_d.guard  = 1'b0;
            s2_d.sticky = 1'b1;
        end else if (int'(s1_scale) < -POSIT16_ES2_MAXSCALE) begin
            s2_d.mag    = POSIT16_MINPOS[14:0];
            s2_d.guard  = 1'b0;
            s2_d.sticky = 1'b1;
        end
    end

    // S2 pipeline register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_q     <= '0;
        end else if (pipe_en) begin
            s2_valid <= s1_valid;
            s2_q     <= s2_d;
        end
    end

    // ---------------- S3: round, sign, special values ----------------
    logic        rnd_inc;
    logic [14:0] rnd_mag;
    logic [15:0] mag_word;
    logic [15:0] s3_posit_d;
    logic        s3_inexact_d, s3_nar_d;
    logic        s3_valid, s3_inexact, s3_nar;
    logic [15:0] s3_posit;

    // Round to nearest even, saturate at maxpos, never round to zero, then apply sign
    always_comb begin
        rnd_inc = s2_q.guard & (s2_q.sticky | s2_q.mag[0]);
        if (s2_q.mag == POSIT16_MAXPOS[14:0]) rnd_mag = POSIT16_MAXPOS[14:0];
        else                                  rnd_mag = s2_q.mag + {14'd0, rnd_inc};
        if (rnd_mag == 15'd0) rnd_mag = POSIT16_MINPOS[14:0];
        mag_word     = {1'b0, rnd_mag};
        s3_posit_d   = s2_q.sgn ? (16'd0 - mag_word) : mag_word;
        s3_inexact_d = s2_q.guard | s2_q.sticky;
        s3_nar_d     = 1'b0;
        if (s2_q.inf) begin
            s3_posit_d   = POSIT16_NAR;
            s3_inexact_d = 1'b0;
            s3_nar_d     = 1'b1;
        end else if (s2_q.zero) begin
            s3_posit_d   = 16'h0000;
            s3_inexact_d = 1'b0;
        end
    end

    // S3 pipeline register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s3_valid   <= 1'b0;
            s3_posit   <= '0;
            s3_inexact <= 1'b0;
            s3_nar     <= 1'b0;
        end else if (pipe_en) begin
            s3_valid   <= s2_valid;
            s3_posit   <= s3_posit_d;
            s3_inexact <= s3_inexact_d;
            s3_nar     <= s3_nar_d;
        end
    end

    // ---------------- flow control and output buffer ----------------
    // Stall depends on registered state only, so out_ready never reaches in_ready combinationally
    assign pipe_en  = ~(s3_valid & skid_full);
    assign in_ready = pipe_en;

    // Sticky record of inputs dropped because the pipe was stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        overrun <= 1'b0;
        else if (in_valid & ~in_ready)  overrun <= 1'b1;
    end

    posit_skid2 #(.W(18)) u_skid (
        .clk      (clk),
        .rst      (rst),
        .s_tdata  ({s3_posit, s3_inexact, s3_nar}),
        .s_tvalid (s3_valid & pipe_en),
        .m_tdata  ({out_posit, out_inexact, out_nar}),
        .m_tvalid (out_valid),
        .m_tready (out_ready),
        .full     (skid_full)
    );

endmodule

// File: tb/tb_positaccum_round_16.sv
// tb/tb_positaccum_round_16.sv - directed self-checking bench for positaccum_round_16
module tb_positaccum_round_16;

    logic         clk = 1'b0;
    logic         rst;
    logic [157:0] in_data;
    logic         in_valid, in_truncated, in_ready;
    logic [15:0]  out_posit;
    logic         out_valid, out_ready, out_inexact, out_nar, overrun;

    int errors = 0;
    int checks = 0;

    // Posits for sgn=0, frac=0, scale 0..7
    logic [15:0] tbl [8] = '{16'h4000, 16'h4800, 16'h5000, 16'h5800,
                             16'h6000, 16'h6400, 16'h6800, 16'h6C00};

    int accepted, stall_cnt, n_out, first_cyc, last_cyc;

    always #5 clk = ~clk;

    positaccum_round_16 dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_truncated (in_truncated),
        .in_ready     (in_ready),
        .out_posit    (out_posit),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_inexact  (out_inexact),
        .out_nar      (out_nar),
        .overrun      (overrun)
    );

    function automatic logic [157:0] mk(input logic sgn, input logic [7:0] scale,
                                        input logic [146:0] frac, input logic inf, input logic zero);
        return {sgn, scale, frac, inf, zero};
    endfunction

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_truncated = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_posit !== 16'h0000) begin errors++; $display("FAIL reset_out_posit: got %h expected 0000", out_posit); end
        checks++; if (out_inexact !== 1'b0) begin errors++; $display("FAIL reset_out_inexact: got %b expected 0", out_inexact); end
        checks++; if (out_nar !== 1'b0) begin errors++; $display("FAIL reset_out_nar: got %b expected 0", out_nar); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    endtask

    // One isolated transfer with out_ready=1; checks latency and the result fields
    task automatic run_one(input string name, input logic [157:0] d, input logic trunc,
                           input logic [15:0] exp_p, input logic exp_inex, input logic exp_nar);
        int lat;
        lat = -1;
        @(posedge clk); #1;
        in_data = d; in_truncated = trunc; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; in_truncated = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (out_valid) begin lat = i - 1; break; end
        end
        checks++; if (lat !== 3) begin errors++; $display("FAIL %s_latency: got %0d expected 3", name, lat); end
        checks++; if (out_posit !== exp_p) begin errors++; $display("FAIL %s_posit: got %h expected %h", name, out_posit, exp_p); end
        checks++; if (out_inexact !== exp_inex) begin errors++; $display("FAIL %s_inexact: got %b expected %b", name, out_inexact, exp_inex); end
        checks++; if (out_nar !== exp_nar) begin errors++; $display("FAIL %s_nar: got %b expected %b", name, out_nar, exp_nar); end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [146:0] f;
        f = '0;
        run_one("one",   mk(1'b0, 8'd0, f, 1'b0, 1'b0), 1'b0, 16'h4000, 1'b0, 1'b0);
        run_one("two",   mk(1'b0, 8'd1, f, 1'b0, 1'b0), 1'b0, 16'h4800, 1'b0, 1'b0);
        run_one("neg1",  mk(1'b1, 8'd0, f, 1'b0, 1'b0), 1'b0, 16'hC000, 1'b0, 1'b0);
        run_one("half",  mk(1'b0, 8'hFF, f, 1'b0, 1'b0), 1'b0, 16'h3800, 1'b0, 1'b0);
        f[146] = 1'b1;
        run_one("neg1p5", mk(1'b1, 8'd0, f, 1'b0, 1'b0), 1'b0, 16'hBC00, 1'b0, 1'b0);
    endtask

    task automatic test_clamp_special();
        logic [146:0] f;
        f = '0;
        run_one("sc60",   mk(1'b0, 8'd60, f, 1'b0, 1'b0), 1'b0, 16'h7FFF, 1'b1, 1'b0);
        run_one("scm60",  mk(1'b0, 8'hC4, f, 1'b0, 1'b0), 1'b0, 16'h0001, 1'b1, 1'b0);
        run_one("sc56",   mk(1'b0, 8'd56, f, 1'b0, 1'b0), 1'b0, 16'h7FFF, 1'b0, 1'b0);
        run_one("sc57",   mk(1'b0, 8'd57, f, 1'b0, 1'b0), 1'b0, 16'h7FFF, 1'b1, 1'b0);
        run_one("scm56",  mk(1'b0, 8'hC8, f, 1'b0, 1'b0), 1'b0, 16'h0001, 1'b0, 1'b0);
        run_one("sc55",   mk(1'b0, 8'd55, f, 1'b0, 1'b0), 1'b0, 16'h7FFF, 1'b1, 1'b0);
        run_one("zero",   mk(1'b0, 8'd3, f, 1'b0, 1'b1), 1'b0, 16'h0000, 1'b0, 1'b0);
        run_one("inf",    mk(1'b1, 8'd3, f, 1'b1, 1'b1), 1'b0, 16'h8000, 1'b0, 1'b1);
    endtask

    task automatic test_rounding();
        logic [146:0] f;
        f = '0; f[135] = 1'b1;
        run_one("tie",     mk(1'b0, 8'd0, f, 1'b0, 1'b0), 1'b0, 16'h4000, 1'b1, 1'b0);
`ifdef POSIT_ACCUM_STICKY_EN
        run_one("tie_trunc", mk(1'b0, 8'd0, f, 1'b0, 1'b0), 1'b1, 16'h4001, 1'b1, 1'b0);
`else
        run_one("tie_trunc", mk(1'b0, 8'd0, f, 1'b0, 1'b0), 1'b1, 16'h4000, 1'b1, 1'b0);
`endif
        f[0] = 1'b1;
        run_one("above_tie", mk(1'b0, 8'd0, f, 1'b0, 1'b0), 1'b0, 16'h4001, 1'b1, 1'b0);
        f = '0; f[134] = 1'b1;
        run_one("below_half", mk(1'b0, 8'd0, f, 1'b0, 1'b0), 1'b0, 16'h4000, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        int n;
        n = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; in_data = mk(1'b0, 8'(c), '0, 1'b0, 1'b0);
            @(negedge clk);
            checks++;
            if (in_ready !== (c < 5)) begin errors++; $display("FAIL b2b_in_ready[%0d]: got %b expected %b", c, in_ready, (c < 5)); end
        end
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL b2b_overrun: got %b expected 1", overrun); end
        @(posedge clk); #1 out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) begin
                if (n < 5) begin
                    checks++;
                    if (out_posit !== tbl[n]) begin errors++; $display("FAIL b2b_order[%0d]: got %h expected %h", n, out_posit, tbl[n]); end
                end
                n++;
            end
        end
        checks++; if (n !== 5) begin errors++; $display("FAIL b2b_count: got %0d expected 5", n); end
    endtask

    task automatic test_full_skid_stream();
        accepted = 0; stall_cnt = 0; n_out = 0; first_cyc = -1; last_cyc = -1;
        out_ready = 1'b0;
        fork
            begin
                for (int c = 0; c < 40 && accepted < 15; c++) begin
                    @(posedge clk); #1;
                    if (accepted >= 5) out_ready = 1'b1;
                    if (in_ready) begin
                        in_valid = 1'b1;
                        in_data  = mk(1'b0, 8'(accepted % 8), '0, 1'b0, 1'b0);
                        accepted++;
                    end else begin
                        in_valid = 1'b0;
                        if (out_ready) stall_cnt++;
                    end
                end
                @(posedge clk); #1 in_valid = 1'b0;
            end
            begin
                for (int c = 0; c < 60; c++) begin
                    @(negedge clk);
                    if (out_valid && out_ready) begin
                        checks++;
                        if (out_posit !== tbl[n_out % 8]) begin errors++; $display("FAIL stream_order[%0d]: got %h expected %h", n_out, out_posit, tbl[n_out % 8]); end
                        if (first_cyc < 0) first_cyc = c;
                        last_cyc = c;
                        n_out++;
                    end
                end
            end
        join
        checks++; if (n_out !== 15) begin errors++; $display("FAIL stream_count: got %0d expected 15", n_out); end
        checks++; if ((last_cyc - first_cyc) !== 14) begin errors++; $display("FAIL stream_rate: got span %0d expected 14", last_cyc - first_cyc); end
        checks++; if (stall_cnt !== 1) begin errors++; $display("FAIL stream_stalls: got %0d expected 1", stall_cnt); end
    endtask

    task automatic test_reset_midflight();
        int stale;
        stale = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; in_data = mk(1'b0, 8'(i), '0, 1'b0, 1'b0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid: got %b expected 1", out_valid); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b expected 0", out_valid); end
        @(posedge clk); #1 rst = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL mid_overrun: got %b expected 0", overrun); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready: got %b expected 1", in_ready); end
        for (int i = 0; i < 10; i++) begin
            if (out_valid) stale++;
            @(negedge clk);
        end
        checks++; if (stale !== 0) begin errors++; $display("FAIL mid_stale: got %0d expected 0", stale); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_clamp_special();
        test_rounding();
        test_back_to_back();
        test_full_skid_stream();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
